// File: rtl/ipm_pkg.sv
// ipm_pkg: shared types and constants for IPM public-vector generation.
package ipm_pkg;
  typedef enum logic [1:0] {IDLE, FILL, OFFER} state_e;
  localparam logic [7:0] L0_CONST = 8'h01;
  localparam logic [7:0] L_RESET_BYTE = 8'h01;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ipm_nonzero_sampler.sv
// ipm_nonzero_sampler: splits the RNG stream into nonzero accepts and zero rejects.
module ipm_nonzero_sampler (
  input  logic       enable,
  input  logic       rnd_valid,
  input  logic [7:0] rnd_data,
  output logic       rnd_ready,
  output logic       accept,
  output logic       reject
);
  assign rnd_ready = enable;
  assign accept = enable & rnd_valid & (|rnd_data);
  assign reject = enable & rnd_valid & ~(|rnd_data);
endmodule

// File: rtl/ipm_public_vector_gen.sv
// ipm_public_vector_gen: builds a fresh nonzero IPM public vector from RNG bytes
// and commits it over the active one once downstream accepts the pair.
module ipm_public_vector_gen
  import ipm_pkg::*;
#(
  parameter int v = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           rnd_valid,
  input  logic [7:0]     rnd_data,
  output logic           rnd_ready,
  output logic           busy,
  output logic [v*8-1:0] L_old,
  output logic [v*8-1:0] L_new,
  output logic           pair_valid,
  input  logic           pair_ready,
  output logic [7:0]     rej_cnt
);
  localparam int IW = idx_w(v);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [v-1:1][7:0] lnew_q, lnew_d, lold_q, lold_d;
  logic [7:0] rej_q, rej_d;
  logic acc, rej;
  ipm_nonzero_sampler u_sampler (
    .enable(state_q == FILL),
    .rnd_valid(rnd_valid),
    .rnd_data(rnd_data),
    .rnd_ready(rnd_ready),
    .accept(acc),
    .reject(rej)
  );
  assign busy = state_q != IDLE;
  assign pair_valid = state_q == OFFER;
  // Byte 0 is a fixed constant, so only entries 1..v-1 are stored.
  assign L_old = {lold_q, L0_CONST};
  assign L_new = {lnew_q, L0_CONST};
  assign rej_cnt = rej_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    lnew_d = lnew_q;
    lold_d = lold_q;
    rej_d = (rej && rej_q != 8'hFF) ? rej_q + 8'd1 : rej_q;
    if (state_q == IDLE && req) begin
      state_d = FILL;
      idx_d = IW'(1);
    end
    if (acc) begin
      lnew_d[idx_q] = rnd_data;
      idx_d = (idx_q == IW'(v - 1)) ? IW'(1) : idx_q + IW'(1);
      state_d = (idx_q == IW'(v - 1)) ? OFFER : FILL;
    end
    if (state_q == OFFER && pair_ready) begin
      lold_d = lnew_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= IW'(1);
      lnew_q <= {(v-1){L_RESET_BYTE}};
      lold_q <= {(v-1){L_RESET_BYTE}};
      rej_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      lnew_q <= lnew_d;
      lold_q <= lold_d;
      rej_q <= rej_d;
    end
  end
endmodule

// File: tb/tb_ipm_public_vector_gen.sv
// tb_ipm_public_vector_gen: directed and random checks against a queue-based reference model.
module tb_ipm_public_vector_gen;
  localparam int V = 3;
  localparam int W = V * 8;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, rnd_valid = 1'b0, pair_ready = 1'b0;
  logic [7:0] rnd_data = 8'h00;
  logic rnd_ready, busy, pair_valid;
  logic [W-1:0] L_old, L_new;
  logic [7:0] rej_cnt;
  int n_chk = 0, n_pass = 0;
  int m_state, m_rej;
  logic [7:0] got[$];
  logic [7:0] q[$];
  logic [W-1:0] m_old, m_new;
  ipm_public_vector_gen #(.v(V)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
    .rnd_ready(rnd_ready), .busy(busy), .L_old(L_old), .L_new(L_new),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .rej_cnt(rej_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic model_reset();
    m_state = 0;
    m_rej = 0;
    got.delete();
    m_old = {V{8'h01}};
    m_new = {V{8'h01}};
  endtask
  // Abstract model: idle -> collect V-1 nonzero bytes -> offer until taken.
  task automatic model_update();
    if (m_state == 0) begin
      if (req) begin
        m_state = 1;
        got.delete();
      end
    end else if (m_state == 1) begin
      if (rnd_valid) begin
        if (rnd_data == 8'h00) m_rej = (m_rej < 255) ? m_rej + 1 : 255;
        else begin
          got.push_back(rnd_data);
          if (got.size() == V - 1) begin
            m_new = {{(V-1){8'h00}}, 8'h01};
            for (int i = 0; i < V - 1; i++) m_new[(i+1)*8 +: 8] = got[i];
            m_state = 2;
          end
        end
      end
    end else if (pair_ready) begin
      m_old = m_new;
      m_state = 0;
    end
  endtask
  task automatic compare_all();
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("rnd_ready", 32'(rnd_ready), 32'(m_state == 1));
    chk("pair_valid", 32'(pair_valid), 32'(m_state == 2));
    chk("rej_cnt", 32'(rej_cnt), 32'(m_rej));
    chk("L_old", 32'(L_old), 32'(m_old));
    if (m_state == 2) chk("L_new", 32'(L_new), 32'(m_new));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask
  task automatic feed();
    req = 1'b1;
    step();
    req = 1'b0;
    foreach (q[i]) begin
      rnd_valid = 1'b1;
      rnd_data = q[i];
      step();
    end
    rnd_valid = 1'b0;
  endtask
  task automatic commit();
    int n;
    n = 0;
    pair_ready = 1'b1;
    while (!pair_valid && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("commit_timeout", 32'(n), 32'(0));
    step();
    pair_ready = 1'b0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_L_new", 32'(L_new), 32'h010101);
    rst_n = 1'b1;
    step();
    q = '{8'hA5, 8'h3C};
    feed();
    chk("lat_pv", 32'(pair_valid), 32'd1);
    chk("vecA", 32'(L_new), 32'h3CA501);
    chk("oldA", 32'(L_old), 32'h010101);
    step();
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
    chk("commitA", 32'(L_old), 32'h3CA501);
    chk("idleA", 32'(busy), 32'd0);
    q = '{8'h00, 8'h7E, 8'h00, 8'h00};
    feed();
    chk("zero_not_done", 32'(pair_valid), 32'd0);
    q = '{8'h11};
    req = 1'b0;
    rnd_valid = 1'b1;
    rnd_data = 8'h11;
    step();
    rnd_valid = 1'b0;
    chk("vecB", 32'(L_new), 32'h117E01);
    chk("rejB", 32'(rej_cnt), 32'd3);
    commit();
    req = 1'b1;
    step();
    req = 1'b0;
    rnd_data = 8'h55; rnd_valid = 1'b1; step();
    rnd_valid = 1'b0; step();
    rnd_data = 8'h66; rnd_valid = 1'b1; step();
    rnd_valid = 1'b0; step();
    for (int i = 0; i < 10; i++) begin
      req = i[0];
      rnd_valid = 1'b1;
      rnd_data = 8'($urandom_range(1, 255));
      step();
      chk("bp_L_new", 32'(L_new), 32'h665501);
      chk("bp_ready", 32'(rnd_ready), 32'd0);
      chk("bp_pv", 32'(pair_valid), 32'd1);
    end
    req = 1'b0;
    rnd_valid = 1'b0;
    commit();
    req = 1'b1;
    step();
    req = 1'b0;
    rnd_valid = 1'b1; rnd_data = 8'hFF;
    step();
    rnd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("arst_L_new", 32'(L_new), 32'h010101);
    chk("arst_L_old", 32'(L_old), 32'h010101);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q = '{8'h12, 8'h34};
    feed();
    chk("vecC", 32'(L_new), 32'h341201);
    commit();
    req = 1'b1;
    step();
    req = 1'b0;
    rnd_valid = 1'b1;
    rnd_data = 8'h00;
    for (int i = 0; i < 300; i++) step();
    chk("sat", 32'(rej_cnt), 32'hFF);
    rnd_data = 8'h01; step();
    rnd_data = 8'h02; step();
    rnd_valid = 1'b0;
    chk("vecD", 32'(L_new), 32'h020101);
    chk("satD", 32'(rej_cnt), 32'hFF);
    commit();
    for (int i = 0; i < 600; i++) begin
      req = ($urandom_range(0, 9) < 3);
      rnd_valid = $urandom_range(0, 1);
      rnd_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      pair_ready = ($urandom_range(0, 9) < 4);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
